alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencer that steps a register-bank/ALU datapath through read, execute and
// write-back for one operation, and loads keypad nibbles into the bank while idle.
module alu_seq_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op_in,
    input  logic [1:0]        addr_a_in,
    input  logic [1:0]        addr_b_in,
    input  logic [1:0]        addr_d_in,
    input  logic              wb_en,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic [1:0]        rf_rd_addr_a,
    output logic [1:0]        rf_rd_addr_b,
    output logic              rf_wr_en,
    output logic [1:0]        rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [1:0]        alu_sel,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              busy,
    output logic              done,
    output logic [1:0]        key_ptr,
    output logic              key_lost
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_WB, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        addr_a_q, addr_a_d;
    logic [1:0]        addr_b_q, addr_b_d;
    logic [1:0]        addr_d_q, addr_d_d;
    logic              wb_en_q, wb_en_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic [1:0]        key_ptr_q, key_ptr_d;
    logic              key_lost_q, key_lost_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_d_q   <= '0;
            wb_en_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            key_ptr_q  <= '0;
            key_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            addr_d_q   <= addr_d_d;
            wb_en_q    <= wb_en_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            key_ptr_q  <= key_ptr_d;
            key_lost_q <= key_lost_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        addr_d_d     = addr_d_q;
        wb_en_d      = wb_en_q;
        result_d     = result_q;
        zero_d       = zero_q;
        carry_d      = carry_q;
        key_ptr_d    = key_ptr_q;
        key_lost_d   = key_lost_q;
        rf_rd_addr_a = '0;
        rf_rd_addr_b = '0;
        rf_wr_en     = 1'b0;
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        alu_sel      = '0;
        busy         = 1'b0;
        done         = 1'b0;

        // A key is only consumed in IDLE when no start competes for the cycle.
        if (key_valid && !(state_q == S_IDLE && !start))
            key_lost_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RD;
                    op_d     = op_in;
                    addr_a_d = addr_a_in;
                    addr_b_d = addr_b_in;
                    addr_d_d = addr_d_in;
                    wb_en_d  = wb_en;
                end else if (key_valid && !reset) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = key_ptr_q;
                    rf_wr_data = {{(DATA_W-4){1'b0}}, key_code};
                    key_ptr_d  = key_ptr_q + 2'd1;
                end
            end
            S_RD, S_EX, S_WB: begin
                busy         = 1'b1;
                rf_rd_addr_a = addr_a_q;
                rf_rd_addr_b = addr_b_q;
                alu_sel      = op_q;
                if (state_q == S_RD) begin
                    state_d = S_EX;
                end else if (state_q == S_EX) begin
                    state_d  = S_WB;
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    carry_d  = alu_carry;
                end else begin
                    state_d    = S_DONE;
                    rf_wr_en   = wb_en_q;
                    rf_wr_addr = wb_en_q ? addr_d_q : 2'd0;
                    rf_wr_data = wb_en_q ? result_q : '0;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign result     = result_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign key_ptr    = key_ptr_q;
    assign key_lost   = key_lost_q;

endmodule
